// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizing, tag type, entry layout
// and the circular tag-increment helper. Tags run 1..DEPTH; tag 0 means
// "no dependency".
package reorder_buffer_pkg;

    localparam int ROB_SZ_LOG = 3;
    localparam int TAG_W      = ROB_SZ_LOG + 1;
    localparam int DEPTH      = 15;
    localparam int NUM_SLOTS  = 1 << TAG_W;
    localparam int REG_SZ_LOG = 5;
    localparam int XLEN       = 32;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_NONE  = tag_t'(0);
    localparam tag_t TAG_FIRST = tag_t'(1);

    typedef struct packed {
        logic                  rd_hv;
        logic [REG_SZ_LOG-1:0] rd;
        logic                  is_br;
        logic                  pred_taken;
        logic [XLEN-1:0]       alt_pc;
        logic [XLEN-1:0]       value;
        logic                  taken;
    } rob_entry_t;

    // Advance a tag around the ring; DEPTH wraps back to the first real tag.
    function automatic tag_t tag_inc(input tag_t t);
        if (t == tag_t'(DEPTH)) begin
            return TAG_FIRST;
        end else begin
            return t + tag_t'(1);
        end
    endfunction

endpackage

// File: rtl/reorder_buffer_query_port.sv
// Operand-readiness lookup into the reorder buffer for one source register.
// Optional macro ROB_BYPASS_EN: also forward results being written back on
// either CDB in the same cycle.
module rob_query_port
    import reorder_buffer_pkg::*;
(
    input  tag_t                           id_i,
    input  logic [NUM_SLOTS-1:0]           busy_i,
    input  logic [NUM_SLOTS-1:0]           ready_i,
    input  logic [NUM_SLOTS-1:0][XLEN-1:0] value_i,
    input  logic                           wb_en_i,
    input  logic                           cdb0_valid_i,
    input  tag_t                           cdb0_tag_i,
    input  logic [XLEN-1:0]                cdb0_value_i,
    input  logic                           cdb1_valid_i,
    input  tag_t                           cdb1_tag_i,
    input  logic [XLEN-1:0]                cdb1_value_i,
    output logic                           ready_o,
    output logic [XLEN-1:0]                value_o
);

    logic hit_s;

`ifdef ROB_BYPASS_EN
    logic byp0_s;
    logic byp1_s;

    // Stored result lookup, overridden by a matching in-flight writeback.
    always_comb begin
        hit_s   = (id_i != TAG_NONE) && busy_i[id_i] && ready_i[id_i];
        byp0_s  = wb_en_i && cdb0_valid_i && (cdb0_tag_i == id_i) &&
                  (id_i != TAG_NONE) && busy_i[id_i];
        byp1_s  = wb_en_i && cdb1_valid_i && (cdb1_tag_i == id_i) &&
                  (id_i != TAG_NONE) && busy_i[id_i];
        ready_o = 1'b0;
        value_o = '0;
        if (byp0_s) begin
            ready_o = 1'b1;
            value_o = cdb0_value_i;
        end else if (byp1_s) begin
            ready_o = 1'b1;
            value_o = cdb1_value_i;
        end else if (hit_s) begin
            ready_o = 1'b1;
            value_o = value_i[id_i];
        end else begin
            ready_o = 1'b0;
            value_o = '0;
        end
    end
`else
    logic unused_cdb_s;
    assign unused_cdb_s = ^{wb_en_i, cdb0_valid_i, cdb0_tag_i, cdb0_value_i,
                            cdb1_valid_i, cdb1_tag_i, cdb1_value_i};

    // Stored result lookup only; writebacks show up after they are captured.
    always_comb begin
        hit_s   = (id_i != TAG_NONE) && busy_i[id_i] && ready_i[id_i];
        ready_o = 1'b0;
        value_o = '0;
        if (hit_s) begin
            ready_o = 1'b1;
            value_o = value_i[id_i];
        end else begin
            ready_o = 1'b0;
            value_o = '0;
        end
    end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at tail, accepts two CDB writebacks,
// retires in order at head and raises a flush on branch mispredict.
// Optional macro ROB_BYPASS_EN is handled inside rob_query_port.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  alloc_valid,
    input  logic                  alloc_rd_hv,
    input  logic [REG_SZ_LOG-1:0] alloc_rd,
    input  logic                  alloc_is_br,
    input  logic                  alloc_pred_taken,
    input  logic [XLEN-1:0]       alloc_alt_pc,
    output tag_t                  tail,
    output logic                  full,
    input  logic                  cdb0_valid,
    input  tag_t                  cdb0_tag,
    input  logic [XLEN-1:0]       cdb0_value,
    input  logic                  cdb0_taken,
    input  logic                  cdb1_valid,
    input  tag_t                  cdb1_tag,
    input  logic [XLEN-1:0]       cdb1_value,
    input  logic                  cdb1_taken,
    input  tag_t                  rs1_id,
    input  tag_t                  rs2_id,
    output logic                  rob_rs1_ready,
    output logic                  rob_rs2_ready,
    output logic [XLEN-1:0]       rob_rs1_value,
    output logic [XLEN-1:0]       rob_rs2_value,
    output logic                  run_upd,
    output logic [REG_SZ_LOG-1:0] commit_rd,
    output logic [XLEN-1:0]       res,
    output tag_t                  head,
    output logic                  reset,
    output logic [XLEN-1:0]       redirect_pc
);

    tag_t                           head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [NUM_SLOTS-1:0]           busy_q, busy_d, ready_q, ready_d;
    rob_entry_t [NUM_SLOTS-1:0]     ent_q, ent_d;
    logic                           run_upd_q, run_upd_d, reset_q, reset_d;
    logic [REG_SZ_LOG-1:0]          commit_rd_q, commit_rd_d;
    logic [XLEN-1:0]                res_q, res_d, redirect_q, redirect_d;
    tag_t                           head_out_q, head_out_d;
    logic                           full_s, commit_s, mispred_s, alloc_s;
    logic                           wb0_s, wb1_s, wb_en_s;
    rob_entry_t                     head_ent_s;
    logic [NUM_SLOTS-1:0][XLEN-1:0] values_s;

    // Decode this cycle's commit, mispredict, allocation and writeback events.
    always_comb begin
        wb_en_s    = rdy && !reset_q;
        full_s     = (count_q == tag_t'(DEPTH));
        head_ent_s = ent_q[head_q];
        commit_s   = busy_q[head_q] && ready_q[head_q];
        mispred_s  = commit_s && head_ent_s.is_br &&
                     (head_ent_s.taken != head_ent_s.pred_taken);
        alloc_s    = alloc_valid && !full_s && !reset_q && !mispred_s;
        wb0_s      = cdb0_valid && (cdb0_tag != TAG_NONE) && busy_q[cdb0_tag] && !reset_q;
        wb1_s      = cdb1_valid && (cdb1_tag != TAG_NONE) && busy_q[cdb1_tag] && !reset_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            values_s[i] = ent_q[i].value;
        end
    end

    // Next state of every entry, the ring pointers and the commit outputs.
    always_comb begin
        ent_d       = ent_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        run_upd_d   = 1'b0;
        commit_rd_d = commit_rd_q;
        res_d       = res_q;
        head_out_d  = head_out_q;
        reset_d     = mispred_s;
        redirect_d  = mispred_s ? head_ent_s.alt_pc : redirect_q;

        for (int i = 1; i <= DEPTH; i++) begin
            if (mispred_s) begin
                busy_d[i]  = 1'b0;
                ready_d[i] = 1'b0;
            end else if (alloc_s && (tail_q == tag_t'(i))) begin
                busy_d[i]           = 1'b1;
                ready_d[i]          = 1'b0;
                ent_d[i].rd_hv      = alloc_rd_hv;
                ent_d[i].rd         = alloc_rd;
                ent_d[i].is_br      = alloc_is_br;
                ent_d[i].pred_taken = alloc_pred_taken;
                ent_d[i].alt_pc     = alloc_alt_pc;
                ent_d[i].value      = '0;
                ent_d[i].taken      = 1'b0;
            end else if (commit_s && (head_q == tag_t'(i))) begin
                busy_d[i]  = 1'b0;
                ready_d[i] = 1'b0;
            end else if (wb0_s && (cdb0_tag == tag_t'(i))) begin
                ready_d[i]      = 1'b1;
                ent_d[i].value  = cdb0_value;
                ent_d[i].taken  = cdb0_taken;
            end else if (wb1_s && (cdb1_tag == tag_t'(i))) begin
                ready_d[i]      = 1'b1;
                ent_d[i].value  = cdb1_value;
                ent_d[i].taken  = cdb1_taken;
            end else begin
                busy_d[i]  = busy_q[i];
                ready_d[i] = ready_q[i];
            end
        end

        if (mispred_s) begin
            head_d  = TAG_FIRST;
            tail_d  = TAG_FIRST;
            count_d = tag_t'(0);
        end else begin
            head_d  = commit_s ? tag_inc(head_q) : head_q;
            tail_d  = alloc_s ? tag_inc(tail_q) : tail_q;
            count_d = count_q + tag_t'(alloc_s) - tag_t'(commit_s);
        end

        if (commit_s) begin
            run_upd_d   = 1'b1;
            commit_rd_d = head_ent_s.rd_hv ? head_ent_s.rd : {REG_SZ_LOG{1'b0}};
            res_d       = head_ent_s.value;
            head_out_d  = head_q;
        end else begin
            run_upd_d   = 1'b0;
        end
    end

    // State and commit-interface registers; everything holds while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= TAG_FIRST;
            tail_q      <= TAG_FIRST;
            count_q     <= tag_t'(0);
            busy_q      <= '0;
            ready_q     <= '0;
            ent_q       <= '0;
            run_upd_q   <= 1'b0;
            commit_rd_q <= {REG_SZ_LOG{1'b0}};
            res_q       <= {XLEN{1'b0}};
            head_out_q  <= TAG_NONE;
            reset_q     <= 1'b0;
            redirect_q  <= {XLEN{1'b0}};
        end else if (rdy) begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            ent_q       <= ent_d;
            run_upd_q   <= run_upd_d;
            commit_rd_q <= commit_rd_d;
            res_q       <= res_d;
            head_out_q  <= head_out_d;
            reset_q     <= reset_d;
            redirect_q  <= redirect_d;
        end
    end

    rob_query_port u_rs1_query (
        .id_i(rs1_id), .busy_i(busy_q), .ready_i(ready_q), .value_i(values_s),
        .wb_en_i(wb_en_s),
        .cdb0_valid_i(cdb0_valid), .cdb0_tag_i(cdb0_tag), .cdb0_value_i(cdb0_value),
        .cdb1_valid_i(cdb1_valid), .cdb1_tag_i(cdb1_tag), .cdb1_value_i(cdb1_value),
        .ready_o(rob_rs1_ready), .value_o(rob_rs1_value)
    );

    rob_query_port u_rs2_query (
        .id_i(rs2_id), .busy_i(busy_q), .ready_i(ready_q), .value_i(values_s),
        .wb_en_i(wb_en_s),
        .cdb0_valid_i(cdb0_valid), .cdb0_tag_i(cdb0_tag), .cdb0_value_i(cdb0_value),
        .cdb1_valid_i(cdb1_valid), .cdb1_tag_i(cdb1_tag), .cdb1_value_i(cdb1_value),
        .ready_o(rob_rs2_ready), .value_o(rob_rs2_value)
    );

    assign tail        = tail_q;
    assign full        = full_s;
    assign run_upd     = run_upd_q;
    assign commit_rd   = commit_rd_q;
    assign res         = res_q;
    assign head        = head_out_q;
    assign reset       = reset_q;
    assign redirect_pc = redirect_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued when the
// enabling writeback is issued, a monitor pops them on every run_upd pulse.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

`ifdef ROB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rdy, alloc_valid, alloc_rd_hv, alloc_is_br, alloc_pred_taken;
    logic [4:0] alloc_rd;
    logic [31:0] alloc_alt_pc;
    tag_t tail;
    logic full;
    logic cdb0_valid, cdb1_valid, cdb0_taken, cdb1_taken;
    tag_t cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_value, cdb1_value;
    tag_t rs1_id, rs2_id;
    logic rob_rs1_ready, rob_rs2_ready;
    logic [31:0] rob_rs1_value, rob_rs2_value;
    logic run_upd, reset;
    logic [4:0] commit_rd;
    logic [31:0] res, redirect_pc;
    tag_t head;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd_hv(alloc_rd_hv), .alloc_rd(alloc_rd),
        .alloc_is_br(alloc_is_br), .alloc_pred_taken(alloc_pred_taken),
        .alloc_alt_pc(alloc_alt_pc), .tail(tail), .full(full),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
        .cdb0_taken(cdb0_taken),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
        .cdb1_taken(cdb1_taken),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
        .rob_rs1_value(rob_rs1_value), .rob_rs2_value(rob_rs2_value),
        .run_upd(run_upd), .commit_rd(commit_rd), .res(res), .head(head),
        .reset(reset), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [3:0]  head;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic last_rdy = 1'b0;

    // rdy as seen by the most recent active edge.
    always @(posedge clk) last_rdy <= rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] r, input logic [3:0] h,
                        input logic fl, input logic [31:0] pc);
        exp_t e;
        e.rd = rd; e.res = r; e.head = h; e.flush = fl; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && run_upd && last_rdy) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got head=%0d expected no commit", head);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_rd", {27'd0, commit_rd}, {27'd0, e.rd});
                    chk("res", res, e.res);
                    chk("head", {28'd0, head}, {28'd0, e.head});
                    chk("flush", {31'd0, reset}, {31'd0, e.flush});
                    if (e.flush) chk("redirect_pc", redirect_pc, e.pc);
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_inputs();
        alloc_valid = 1'b0; alloc_rd_hv = 1'b0; alloc_rd = 5'd0; alloc_is_br = 1'b0;
        alloc_pred_taken = 1'b0; alloc_alt_pc = 32'd0;
        cdb0_valid = 1'b0; cdb0_tag = 4'd0; cdb0_value = 32'd0; cdb0_taken = 1'b0;
        cdb1_valid = 1'b0; cdb1_tag = 4'd0; cdb1_value = 32'd0; cdb1_taken = 1'b0;
        rs1_id = 4'd0; rs2_id = 4'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy = 1'b1;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic set_alloc(input logic hv, input logic [4:0] rd, input logic br,
                             input logic pt, input logic [31:0] pc);
        alloc_valid = 1'b1; alloc_rd_hv = hv; alloc_rd = rd; alloc_is_br = br;
        alloc_pred_taken = pt; alloc_alt_pc = pc;
    endtask

    task automatic alloc(input logic hv, input logic [4:0] rd, input logic br,
                         input logic pt, input logic [31:0] pc);
        set_alloc(hv, rd, br, pt, pc);
        cyc();
        alloc_valid = 1'b0;
    endtask

    task automatic wb0(input tag_t t, input logic [31:0] v, input logic tk);
        cdb0_valid = 1'b1; cdb0_tag = t; cdb0_value = v; cdb0_taken = tk;
        cyc();
        cdb0_valid = 1'b0;
    endtask

    task automatic wb1(input tag_t t, input logic [31:0] v, input logic tk);
        cdb1_valid = 1'b1; cdb1_tag = t; cdb1_value = v; cdb1_taken = tk;
        cyc();
        cdb1_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d commits outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        clear_inputs();
        fork
            monitor();
        join_none
        idle(2);
        do_reset();

        // Reset state and basic alloc/writeback/commit
        chk("rst_tail", {28'd0, tail}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_run_upd", {31'd0, run_upd}, 32'd0);
        chk("rst_reset", {31'd0, reset}, 32'd0);
        chk("rst_commit_rd", {27'd0, commit_rd}, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_head", {28'd0, head}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        alloc(1'b1, 5'd5, 1'b0, 1'b0, 32'd0);
        chk("tail_after_alloc", {28'd0, tail}, 32'd2);
        rs1_id = 4'd1;
        cdb0_valid = 1'b1; cdb0_tag = 4'd1; cdb0_value = 32'h12345678; cdb0_taken = 1'b0;
        #1;
        chk("q_same_cycle_ready", {31'd0, rob_rs1_ready}, {31'd0, BYP});
        chk("q_same_cycle_value", rob_rs1_value, BYP ? 32'h12345678 : 32'd0);
        push(5'd5, 32'h12345678, 4'd1, 1'b0, 32'd0);
        cyc();
        cdb0_valid = 1'b0;
        chk("q_after_wb_ready", {31'd0, rob_rs1_ready}, 32'd1);
        chk("q_after_wb_value", rob_rs1_value, 32'h12345678);
        chk("no_commit_yet", {31'd0, run_upd}, 32'd0);
        cyc();
        chk("commit_pulse", {31'd0, run_upd}, 32'd1);
        drain("basic");

        // Out-of-order writeback, in-order retirement
        do_reset();
        alloc(1'b1, 5'd1, 1'b0, 1'b0, 32'd0);
        alloc(1'b0, 5'd2, 1'b0, 1'b0, 32'd0);
        wb1(4'd2, 32'h22, 1'b0);
        idle(3);
        chk("ooo_no_commit", {31'd0, run_upd}, 32'd0);
        push(5'd1, 32'h11, 4'd1, 1'b0, 32'd0);
        push(5'd0, 32'h22, 4'd2, 1'b0, 32'd0);
        wb0(4'd1, 32'h11, 1'b0);
        cyc();
        chk("ooo_first_head", {28'd0, head}, 32'd1);
        cyc();
        chk("ooo_second_pulse", {31'd0, run_upd}, 32'd1);
        chk("ooo_second_head", {28'd0, head}, 32'd2);
        cyc();
        chk("ooo_idle", {31'd0, run_upd}, 32'd0);
        drain("ooo");

        // Fill, overflow, commit-and-refill with wrap
        do_reset();
        for (int i = 1; i <= 15; i++) alloc(1'b1, 5'(i), 1'b0, 1'b0, 32'd0);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_tail", {28'd0, tail}, 32'd1);
        alloc(1'b1, 5'd31, 1'b0, 1'b0, 32'd0);
        chk("ovf_tail", {28'd0, tail}, 32'd1);
        chk("ovf_full", {31'd0, full}, 32'd1);
        push(5'd1, 32'h101, 4'd1, 1'b0, 32'd0);
        wb0(4'd1, 32'h101, 1'b0);
        cyc();
        chk("after_commit_full", {31'd0, full}, 32'd0);
        alloc(1'b1, 5'd20, 1'b0, 1'b0, 32'd0);
        chk("wrap_tail", {28'd0, tail}, 32'd2);
        chk("wrap_full", {31'd0, full}, 32'd1);
        for (int j = 2; j <= 14; j += 2) begin
            push(5'(j), 32'h100 + 32'(j), 4'(j), 1'b0, 32'd0);
            push(5'(j + 1), 32'h100 + 32'(j + 1), 4'(j + 1), 1'b0, 32'd0);
            cdb0_valid = 1'b1; cdb0_tag = 4'(j); cdb0_value = 32'h100 + 32'(j);
            cdb1_valid = 1'b1; cdb1_tag = 4'(j + 1); cdb1_value = 32'h100 + 32'(j + 1);
            cyc();
        end
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
        push(5'd20, 32'h555, 4'd1, 1'b0, 32'd0);
        wb1(4'd1, 32'h555, 1'b0);
        drain("wrap");
        cyc();
        chk("wrap_empty_full", {31'd0, full}, 32'd0);
        chk("wrap_end_tail", {28'd0, tail}, 32'd2);

        // Branch mispredict flush
        do_reset();
        alloc(1'b0, 5'd0, 1'b1, 1'b0, 32'h100);
        alloc(1'b1, 5'd2, 1'b0, 1'b0, 32'd0);
        alloc(1'b1, 5'd3, 1'b0, 1'b0, 32'd0);
        wb1(4'd2, 32'd9, 1'b0);
        push(5'd0, 32'hB0, 4'd1, 1'b1, 32'h100);
        wb0(4'd1, 32'hB0, 1'b1);
        set_alloc(1'b1, 5'd9, 1'b0, 1'b0, 32'd0);
        rs1_id = 4'd2;
        cyc();
        chk("mp_reset", {31'd0, reset}, 32'd1);
        chk("mp_redirect", redirect_pc, 32'h100);
        chk("mp_tail", {28'd0, tail}, 32'd1);
        chk("mp_full", {31'd0, full}, 32'd0);
        chk("mp_rs1_ready", {31'd0, rob_rs1_ready}, 32'd0);
        cdb0_valid = 1'b1; cdb0_tag = 4'd1; cdb0_value = 32'h77;
        cyc();
        alloc_valid = 1'b0;
        cdb0_valid = 1'b0;
        chk("flush_alloc_ignored", {28'd0, tail}, 32'd1);
        chk("flush_pulse_end", {31'd0, reset}, 32'd0);
        chk("flush_no_commit", {31'd0, run_upd}, 32'd0);
        alloc(1'b1, 5'd4, 1'b0, 1'b0, 32'd0);
        chk("post_flush_tail", {28'd0, tail}, 32'd2);
        drain("mispredict");

        // Operand queries
        do_reset();
        alloc(1'b1, 5'd1, 1'b0, 1'b0, 32'd0);
        alloc(1'b1, 5'd2, 1'b0, 1'b0, 32'd0);
        alloc(1'b1, 5'd3, 1'b0, 1'b0, 32'd0);
        rs1_id = 4'd3;
        rs2_id = 4'd2;
        cdb1_valid = 1'b1; cdb1_tag = 4'd3; cdb1_value = 32'd7;
        #1;
        chk("q3_same_ready", {31'd0, rob_rs1_ready}, {31'd0, BYP});
        chk("q3_same_value", rob_rs1_value, BYP ? 32'd7 : 32'd0);
        cyc();
        cdb1_valid = 1'b0;
        chk("q3_ready", {31'd0, rob_rs1_ready}, 32'd1);
        chk("q3_value", rob_rs1_value, 32'd7);
        chk("q2_not_ready", {31'd0, rob_rs2_ready}, 32'd0);
        chk("q2_value_zero", rob_rs2_value, 32'd0);
        rs2_id = 4'd0;
        #1;
        chk("q0_ready", {31'd0, rob_rs2_ready}, 32'd0);

        // Pause with rdy, then asynchronous reset mid-operation
        do_reset();
        alloc(1'b1, 5'd4, 1'b0, 1'b0, 32'd0);
        wb0(4'd1, 32'h44, 1'b0);
        rdy = 1'b0;
        set_alloc(1'b1, 5'd8, 1'b0, 1'b0, 32'd0);
        cyc();
        chk("pause_no_commit", {31'd0, run_upd}, 32'd0);
        idle(2);
        chk("pause_still_none", {31'd0, run_upd}, 32'd0);
        chk("pause_tail_hold", {28'd0, tail}, 32'd2);
        alloc_valid = 1'b0;
        push(5'd4, 32'h44, 4'd1, 1'b0, 32'd0);
        rdy = 1'b1;
        cyc();
        chk("resume_commit", {31'd0, run_upd}, 32'd1);
        alloc(1'b1, 5'd6, 1'b0, 1'b0, 32'd0);
        drain("pause");
        rst = 1'b0;
        #1;
        chk("arst_commit_rd", {27'd0, commit_rd}, 32'd0);
        chk("arst_res", res, 32'd0);
        chk("arst_head", {28'd0, head}, 32'd0);
        chk("arst_tail", {28'd0, tail}, 32'd1);
        chk("arst_run_upd", {31'd0, run_upd}, 32'd0);
        chk("arst_reset", {31'd0, reset}, 32'd0);
        #2;
        rst = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
